// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the arithmetic blocks.
//   op_t            : operation select (OP_ADD / OP_SUB).
//   signed_overflow : two's-complement overflow rule, given the sign bits of
//                     operand A, the effective operand B (already inverted for
//                     subtraction) and the result.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Overflow happens only when both addends carry the same sign and the
  // result's sign differs from it.
  function automatic logic signed_overflow(
    input logic a_msb,
    input logic b_eff_msb,
    input logic sum_msb
  );
    return (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice
//   Purely combinational CHUNK-bit adder used as one stage of the pipelined
//   adder.
//   Ports:
//     a, b  : CHUNK-bit addends
//     cin   : carry into bit 0
//     sum   : CHUNK-bit result
//     cout  : carry out of bit CHUNK-1
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  // One bit wider than the operands so the carry is never lost.
  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined two's-complement add/subtract unit. The WIDTH-bit operands are
//   cut into STAGES slices of CHUNK = WIDTH/STAGES bits; stage k adds slice k
//   and hands its carry to stage k+1 through a register. Result latency is
//   STAGES register stages, throughput one operation per cycle.
//
//   Ports:
//     clk, rst_n        : rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready : input handshake for a, b, op, carry_in
//     a, b              : WIDTH-bit operands
//     op                : OP_ADD (a+b+carry_in) or OP_SUB (a+~b+1)
//     carry_in          : carry into bit 0, used by OP_ADD only
//     out_valid/out_ready : output handshake for sum, carry_out, overflow
//     sum               : WIDTH-bit result
//     carry_out         : carry out of the MSB (for OP_SUB: 1 = no borrow)
//     overflow          : signed overflow of the operation
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The whole pipeline moves as one (adv = !out_valid ||
//   out_ready); in_ready equals adv and depends only on out_valid and
//   out_ready, never on in_valid. While out_valid && !out_ready every stage,
//   valid bits included, holds, so the result fields stay stable and no new
//   input is taken even if bubbles are in flight.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH)) begin : g_bad_stages
    $error("pipelined_adder: STAGES (%0d) must lie in 1..WIDTH (%0d)", STAGES, WIDTH);
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1: invert B once at the input and force the
  // initial carry; the slices themselves only ever add.
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign cin0  = (op == OP_SUB) ? 1'b1 : carry_in;

  // Stage k registers:
  //   valid_q  - the operation in this stage is real (not a bubble)
  //   carry_q  - carry out of slice k, feeding slice k+1
  //   sum_q    - completed low slices 0..k of the result
  //   g_rem.*  - not-yet-added slices k+1..STAGES-1 of a and b_eff, shifted
  //              down so the next stage always finds its slice at bit 0
  //   g_last.ovf_q - overflow, computed where the sign bits are summed
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;
    localparam bit LAST = (k == STAGES - 1);

    logic             v_d;
    logic             c_d;
    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic [CHUNK-1:0] s_sum;
    logic             s_cout;
    logic [DONE-1:0]  sum_d;

    logic             valid_q;
    logic             carry_q;
    logic [DONE-1:0]  sum_q;

    if (k == 0) begin : g_src
      assign v_d   = in_valid;
      assign c_d   = cin0;
      assign sa    = a[CHUNK-1:0];
      assign sb    = b_eff[CHUNK-1:0];
      assign sum_d = s_sum;
    end else begin : g_src
      assign v_d   = g_stage[k-1].valid_q;
      assign c_d   = g_stage[k-1].carry_q;
      assign sa    = g_stage[k-1].g_rem.rem_a_q[CHUNK-1:0];
      assign sb    = g_stage[k-1].g_rem.rem_b_q[CHUNK-1:0];
      assign sum_d = {s_sum, g_stage[k-1].sum_q};
    end

    adder_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a    (sa),
      .b    (sb),
      .cin  (c_d),
      .sum  (s_sum),
      .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= v_d;
        carry_q <= s_cout;
        sum_q   <= sum_d;
      end
    end

    if (!LAST) begin : g_rem
      localparam int REM = WIDTH - DONE;

      logic [REM-1:0] rem_a_d;
      logic [REM-1:0] rem_b_d;
      logic [REM-1:0] rem_a_q;
      logic [REM-1:0] rem_b_q;

      if (k == 0) begin : g_from
        assign rem_a_d = a[WIDTH-1:CHUNK];
        assign rem_b_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_from
        assign rem_a_d = g_stage[k-1].g_rem.rem_a_q[REM+CHUNK-1:CHUNK];
        assign rem_b_d = g_stage[k-1].g_rem.rem_b_q[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (adv) begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end else begin : g_last
      logic ovf_q;

      // The top slice holds the sign bits of a, b_eff and the result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= signed_overflow(sa[CHUNK-1], sb[CHUNK-1], s_sum[CHUNK-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign carry_out = g_stage[STAGES-1].carry_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule
